// File: rtl/add_operand_sequencer_pkg.sv
// Shared types for the operand sequencer that feeds the two-half serial adder.
package add_operand_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SUM   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Two's-complement overflow: like-signed operands whose sum flips sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_operand_sequencer_if.sv
// Operand input stream and result output stream of the sequencer.
interface add_operand_sequencer_if #(parameter int N = 64);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/add_operand_sequencer_sync_fifo.sv
// Synchronous FIFO with registered occupancy; a push into a full FIFO is refused
// even when a pop happens on the same edge.
module sync_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end
endmodule

// File: rtl/add_operand_sequencer.sv
// Issues buffered operand pairs to the external serial adder, one LOAD/SHIFT/SUM
// pass each, and returns sum/carry/overflow on a valid/ready stream.
module add_operand_sequencer
  import add_operand_sequencer_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  add_operand_sequencer_if.slave  bus,
  output logic [$clog2(DEPTH):0]  o_fifo_count,
  output logic                    o_add_rst_n,
  output logic [N-1:0]            o_add_inp1,
  output logic [N-1:0]            o_add_inp2,
  input  logic [N-1:0]            i_add_sum,
  input  logic                    i_add_cout
);
  if ((N % 2) != 0) begin : g_bad_width
    $error("add_operand_sequencer: N must be even");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("add_operand_sequencer: DEPTH must be a power of two >= 2");
  end

  state_t         r_state;
  logic [N-1:0]   r_op_a;
  logic [N-1:0]   r_op_b;
  logic           r_out_valid;
  logic [N-1:0]   r_out_sum;
  logic           r_out_cout;
  logic           r_out_ovf;
  logic           r_add_rst_n;

  logic [2*N-1:0] w_fifo_rdata;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [N-1:0]   w_head_a;
  logic [N-1:0]   w_head_b;
  logic           w_out_hs;
  logic           w_pop;

  sync_fifo #(.W(2*N), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (bus.in_valid),
    .i_pop   (w_pop),
    .i_wdata ({bus.in_a, bus.in_b}),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (o_fifo_count)
  );

  assign w_head_a = w_fifo_rdata[2*N-1:N];
  assign w_head_b = w_fifo_rdata[N-1:0];
  assign w_out_hs = r_out_valid && bus.out_ready;

  always_comb begin
    w_pop = !w_fifo_empty && ((r_state == ST_IDLE) || ((r_state == ST_DRAIN) && w_out_hs));
  end

  // add_rst_n rises on the pop edge, so the adder sees it low on that edge and
  // starts its own LOAD phase in step with ST_LOAD.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_add_rst_n <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_op_a      <= w_head_a;
            r_op_b      <= w_head_b;
            r_add_rst_n <= 1'b1;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD:  r_state <= ST_SHIFT;
        ST_SHIFT: r_state <= ST_SUM;
        ST_SUM: begin
          r_out_sum   <= i_add_sum;
          r_out_cout  <= i_add_cout;
          r_out_ovf   <= signed_ovf(r_op_a[N-1], r_op_b[N-1], i_add_sum[N-1]);
          r_out_valid <= 1'b1;
          r_add_rst_n <= 1'b0;
          r_state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            if (w_pop) begin
              r_op_a      <= w_head_a;
              r_op_b      <= w_head_b;
              r_add_rst_n <= 1'b1;
              r_state     <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_add_rst_n <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = !w_fifo_full;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_ovf   = r_out_ovf;
  assign o_add_rst_n   = r_add_rst_n;
  assign o_add_inp1    = r_op_a;
  assign o_add_inp2    = r_op_b;
endmodule
